// File: rtl/avalon_sram_bridge_if.sv
// Avalon-MM slave-side signal bundle for avalon_sram_bridge.
// The slave modport is the bridge's view; master is the interconnect's view.
interface avalon_sram_bridge_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AV_ADDR_W = 32,
  parameter int unsigned RSP_DEPTH = 4
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned RW = $clog2(RSP_DEPTH + 1);

  logic                 read_n;
  logic                 write_n;
  logic [AV_ADDR_W-1:0] address;
  logic [DATA_W-1:0]    writeData;
  logic [NB-1:0]        byteEnable_n;
  logic [DATA_W-1:0]    readData;
  logic                 waitrequest;
  logic                 readdatavalid;
  logic [RW-1:0]        rd_outstanding;

  modport slave (
    input  read_n, write_n, address, writeData, byteEnable_n,
    output readData, waitrequest, readdatavalid, rd_outstanding
  );

  modport master (
    output read_n, write_n, address, writeData, byteEnable_n,
    input  readData, waitrequest, readdatavalid, rd_outstanding
  );
endinterface

// File: rtl/avalon_sram_bridge.sv
// Avalon-MM slave to asynchronous SRAM bridge: command FIFO, registered SRAM
// strobes with programmable wait states, credit-limited read response FIFO.
module avalon_sram_bridge #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned AV_ADDR_W   = 32,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  avalon_sram_bridge_if.slave   av,
  inout  wire  [DATA_W-1:0]     dq_sram,
  output logic [ADDR_W-1:0]     address_sram,
  output logic                  ce_n_sram,
  output logic                  oe_n_sram,
  output logic                  we_n_sram,
  output logic [DATA_W/8-1:0]   be_n_sram
);
  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned CW  = 1 + ADDR_W + NB + DATA_W;
  localparam int unsigned CPW = $clog2(CMD_DEPTH);
  localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned RPW = $clog2(RSP_DEPTH);
  localparam int unsigned RCW = $clog2(RSP_DEPTH + 1);
  localparam logic [CPW-1:0] CMD_LAST = CPW'(CMD_DEPTH - 1);
  localparam logic [RPW-1:0] RSP_LAST = RPW'(RSP_DEPTH - 1);
  localparam logic [2:0]     WS       = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_HOLD, S_TURN} state_e;

  if (AV_ADDR_W > ADDR_W) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^av.address[AV_ADDR_W-1:ADDR_W];
  end

  // Request side
  logic wr_req, rd_req, waitreq, cmd_push, rd_acc;
  logic [RCW-1:0] rd_out_q;

  logic [CW-1:0]  cmd_mem [CMD_DEPTH];
  logic [CPW-1:0] cmd_wr_q, cmd_rd_q;
  logic [CCW-1:0] cmd_cnt_q;
  logic           cmd_pop, cmd_full, cmd_empty;
  logic [CW-1:0]  cmd_head;

  assign wr_req    = ~av.write_n;
  assign rd_req    = ~av.read_n & av.write_n;
  assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
  assign cmd_empty = (cmd_cnt_q == '0);
  assign waitreq   = cmd_full | (rd_req & (rd_out_q == RCW'(RSP_DEPTH)));
  assign cmd_push  = (wr_req | rd_req) & ~waitreq;
  assign rd_acc    = rd_req & ~waitreq;
  assign cmd_head  = cmd_mem[cmd_rd_q];

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wr_q] <= {wr_req, av.address[ADDR_W-1:0], av.byteEnable_n, av.writeData};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) cmd_wr_q <= (cmd_wr_q == CMD_LAST) ? '0 : cmd_wr_q + 1'b1;
      if (cmd_pop)  cmd_rd_q <= (cmd_rd_q == CMD_LAST) ? '0 : cmd_rd_q + 1'b1;
      cmd_cnt_q <= cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
    end
  end

  // SRAM sequencer; pin registers double as the current command
  state_e            state_q, state_d;
  logic [2:0]        ws_q, ws_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              start, go_idle, rsp_push;

  always_comb begin
    state_d  = state_q;
    ws_d     = ws_q;
    addr_d   = addr_q;
    be_n_d   = be_n_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    dq_oe_d  = dq_oe_q;
    dq_o_d   = dq_o_q;
    start    = 1'b0;
    go_idle  = 1'b0;
    rsp_push = 1'b0;
    cmd_pop  = 1'b0;
    case (state_q)
      S_IDLE:  start = ~cmd_empty;
      S_READ: begin
        if (ws_q != '0) begin
          ws_d = ws_q - 1'b1;
        end else begin
          rsp_push = 1'b1;
          start    = ~cmd_empty;
          go_idle  = cmd_empty;
        end
      end
      S_WRITE: begin
        if (ws_q != '0) begin
          ws_d = ws_q - 1'b1;
        end else begin
          state_d = S_HOLD;
          we_n_d  = 1'b1;
          ce_n_d  = 1'b1;
        end
      end
      // A queued read is only peeked here; TURN pops it once dq is released
      S_HOLD: begin
        if (cmd_empty) begin
          go_idle = 1'b1;
        end else if (cmd_head[CW-1]) begin
          start = 1'b1;
        end else begin
          state_d = S_TURN;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          be_n_d  = '1;
        end
      end
      S_TURN: begin
        start   = ~cmd_empty;
        go_idle = cmd_empty;
      end
      default: go_idle = 1'b1;
    endcase

    if (start) begin
      cmd_pop = 1'b1;
      ws_d    = WS;
      addr_d  = cmd_head[CW-2 -: ADDR_W];
      be_n_d  = cmd_head[DATA_W +: NB];
      ce_n_d  = 1'b0;
      if (cmd_head[CW-1]) begin
        state_d = S_WRITE;
        we_n_d  = 1'b0;
        oe_n_d  = 1'b1;
        dq_oe_d = 1'b1;
        dq_o_d  = cmd_head[DATA_W-1:0];
      end else begin
        state_d = S_READ;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b0;
        dq_oe_d = 1'b0;
      end
    end else if (go_idle) begin
      state_d = S_IDLE;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      dq_oe_d = 1'b0;
      be_n_d  = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ws_q    <= '0;
      addr_q  <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      dq_o_q  <= '0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      dq_o_q  <= dq_o_d;
    end
  end

  assign dq_sram      = dq_oe_q ? dq_o_q : 'z;
  assign address_sram = addr_q;
  assign be_n_sram    = be_n_q;
  assign ce_n_sram    = ce_n_q;
  assign oe_n_sram    = oe_n_q;
  assign we_n_sram    = we_n_q;

  // Response FIFO; credits in rd_out_q guarantee a push never finds it full
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RPW-1:0]    rsp_wr_q, rsp_rd_q;
  logic [RCW-1:0]    rsp_cnt_q;
  logic              rsp_empty, rsp_pop;

  assign rsp_empty = (rsp_cnt_q == '0);
  assign rsp_pop   = ~rsp_empty;

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wr_q] <= dq_sram;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_wr_q  <= '0;
      rsp_rd_q  <= '0;
      rsp_cnt_q <= '0;
      rd_out_q  <= '0;
    end else begin
      if (rsp_push) rsp_wr_q <= (rsp_wr_q == RSP_LAST) ? '0 : rsp_wr_q + 1'b1;
      if (rsp_pop)  rsp_rd_q <= (rsp_rd_q == RSP_LAST) ? '0 : rsp_rd_q + 1'b1;
      rsp_cnt_q <= rsp_cnt_q + RCW'(rsp_push) - RCW'(rsp_pop);
      rd_out_q  <= rd_out_q + RCW'(rd_acc) - RCW'(rsp_pop);
    end
  end

  assign av.readData       = rsp_empty ? '0 : rsp_mem[rsp_rd_q];
  assign av.readdatavalid  = ~rsp_empty;
  assign av.rd_outstanding = rd_out_q;
  assign av.waitrequest    = waitreq;
endmodule

// File: tb/tb_avalon_sram_bridge.sv
// Directed bench for avalon_sram_bridge: one instance with no wait states,
// one with two, each attached to a small behavioural SRAM.
`timescale 1ns/1ps
module tb_avalon_sram_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shared stimulus, steered to one instance by sel (0: WS=0, 1: WS=2)
  logic        sel   = 1'b0;
  logic        rd_n  = 1'b1;
  logic        wr_n  = 1'b1;
  logic [31:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  ben   = '1;

  avalon_sram_bridge_if #(.DATA_W(16), .AV_ADDR_W(32), .RSP_DEPTH(4)) bus0 ();
  avalon_sram_bridge_if #(.DATA_W(16), .AV_ADDR_W(32), .RSP_DEPTH(4)) bus2 ();

  assign bus0.read_n       = sel ? 1'b1 : rd_n;
  assign bus0.write_n      = sel ? 1'b1 : wr_n;
  assign bus0.address      = addr;
  assign bus0.writeData    = wdata;
  assign bus0.byteEnable_n = ben;
  assign bus2.read_n       = sel ? rd_n : 1'b1;
  assign bus2.write_n      = sel ? wr_n : 1'b1;
  assign bus2.address      = addr;
  assign bus2.writeData    = wdata;
  assign bus2.byteEnable_n = ben;

  logic [17:0] asr0, asr2;
  logic        ce0, oe0, we0, ce2, oe2, we2;
  logic [1:0]  be0, be2;
  wire  [15:0] dq0, dq2;

  avalon_sram_bridge #(.DATA_W(16), .ADDR_W(18), .AV_ADDR_W(32), .CMD_DEPTH(4),
                       .RSP_DEPTH(4), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .av(bus0), .dq_sram(dq0), .address_sram(asr0),
    .ce_n_sram(ce0), .oe_n_sram(oe0), .we_n_sram(we0), .be_n_sram(be0));

  avalon_sram_bridge #(.DATA_W(16), .ADDR_W(18), .AV_ADDR_W(32), .CMD_DEPTH(4),
                       .RSP_DEPTH(4), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .av(bus2), .dq_sram(dq2), .address_sram(asr2),
    .ce_n_sram(ce2), .oe_n_sram(oe2), .we_n_sram(we2), .be_n_sram(be2));

  // SRAM models: async read, byte-masked write on clock edges while we_n low
  logic [15:0] mem0 [256];
  logic [15:0] mem2 [256];
  int cont0 = 0;
  int cont2 = 0;

  assign dq0 = (!ce0 && !oe0 && we0) ? mem0[asr0[7:0]] : 'z;
  assign dq2 = (!ce2 && !oe2 && we2) ? mem2[asr2[7:0]] : 'z;

  always @(posedge clk) begin
    if (!ce0 && !we0)
      for (int b = 0; b < 2; b++) if (!be0[b]) mem0[asr0[7:0]][b*8 +: 8] <= dq0[b*8 +: 8];
    if (!oe0 && !we0) cont0 <= cont0 + 1;
  end

  always @(posedge clk) begin
    if (!ce2 && !we2)
      for (int b = 0; b < 2; b++) if (!be2[b]) mem2[asr2[7:0]][b*8 +: 8] <= dq2[b*8 +: 8];
    if (!oe2 && !we2) cont2 <= cont2 + 1;
  end

  logic        wait_m, rdv_m, ce_m, oe_m, we_m;
  logic [15:0] rdata_m, dq_m;
  logic [2:0]  out_m;
  logic [17:0] asr_m;
  logic [1:0]  be_m;

  always_comb begin
    if (sel) begin
      wait_m = bus2.waitrequest; rdv_m = bus2.readdatavalid; rdata_m = bus2.readData;
      out_m  = bus2.rd_outstanding; ce_m = ce2; oe_m = oe2; we_m = we2;
      asr_m  = asr2; be_m = be2; dq_m = dq2;
    end else begin
      wait_m = bus0.waitrequest; rdv_m = bus0.readdatavalid; rdata_m = bus0.readData;
      out_m  = bus0.rd_outstanding; ce_m = ce0; oe_m = oe0; we_m = we0;
      asr_m  = asr0; be_m = be0; dq_m = dq0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rsp_data [$];
  int          rsp_cyc  [$];
  always @(negedge clk) begin
    if (rdv_m) begin
      rsp_data.push_back(rdata_m);
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic av_req(input logic wr, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int stall, output int acc_cyc);
    stall = 0;
    @(posedge clk); #1;
    wr_n = ~wr; rd_n = wr; addr = a; wdata = d; ben = be;
    forever begin
      @(negedge clk);
      if (!wait_m) break;
      stall++;
      if (stall > 40) begin
        chk("req_timeout", 32'(stall), 32'd0);
        break;
      end
    end
    acc_cyc = cyc;
  endtask

  task automatic av_idle();
    @(posedge clk); #1;
    rd_n = 1'b1; wr_n = 1'b1;
  endtask

  int st, ac, ac2, base, we_low, n;
  int rst_st [6];
  int rst_ac [6];

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wait", wait_m, 1'b0);
    chk("rst_rdv", rdv_m, 1'b0);
    chk("rst_rdata", rdata_m, 16'h0);
    chk("rst_out", out_m, 3'd0);
    chk("rst_ce", ce_m, 1'b1);
    chk("rst_oe", oe_m, 1'b1);
    chk("rst_we", we_m, 1'b1);
    chk("rst_be", be_m, 2'b11);
    chk("rst_addr", asr_m, 18'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Single write, WS=0
    av_req(1'b1, 32'h10, 16'hBEEF, 2'b00, st, ac);
    chk("wr1_stall", st, 0);
    av_idle();
    @(negedge clk); chk("wr1_idle_we", we_m, 1'b1);
    @(negedge clk);
    chk("wr1_we", we_m, 1'b0);
    chk("wr1_addr", asr_m, 18'h10);
    chk("wr1_dq", dq_m, 16'hBEEF);
    chk("wr1_be", be_m, 2'b00);
    @(negedge clk);
    chk("wr1_hold_we", we_m, 1'b1);
    chk("wr1_hold_dq", dq_m, 16'hBEEF);
    chk("wr1_hold_addr", asr_m, 18'h10);
    @(negedge clk);
    chk("wr1_end_ce", ce_m, 1'b1);
    chk("wr1_end_wait", wait_m, 1'b0);

    // Read back, latency 3
    av_req(1'b0, 32'h10, 16'h0, 2'b00, st, ac);
    chk("rd1_stall", st, 0);
    av_idle();
    @(negedge clk); chk("rd1_out_t1", out_m, 3'd1); chk("rd1_rdv_t1", rdv_m, 1'b0);
    @(negedge clk); chk("rd1_rdv_t2", rdv_m, 1'b0);
    @(negedge clk);
    chk("rd1_rdv_t3", rdv_m, 1'b1);
    chk("rd1_data", rdata_m, 16'hBEEF);
    chk("rd1_out_t3", out_m, 3'd1);
    @(negedge clk);
    chk("rd1_out_t4", out_m, 3'd0);
    chk("rd1_rdv_t4", rdv_m, 1'b0);
    chk("rd1_rdata_t4", rdata_m, 16'h0);

    // Byte-lane write over 0xFFFF
    av_req(1'b1, 32'h20, 16'hFFFF, 2'b00, st, ac);
    av_idle();
    repeat (4) @(negedge clk);
    av_req(1'b1, 32'h20, 16'hAA55, 2'b10, st, ac);
    av_idle();
    @(negedge clk);
    @(negedge clk);
    chk("be_we", we_m, 1'b0);
    chk("be_pins", be_m, 2'b10);
    repeat (3) @(negedge clk);
    base = rsp_data.size();
    av_req(1'b0, 32'h20, 16'h0, 2'b00, st, ac);
    av_idle();
    repeat (4) @(negedge clk);
    chk("be_rsp_count", rsp_data.size() - base, 1);
    if (rsp_data.size() > base) chk("be_data", rsp_data[base], 16'hFF55);

    // Write then immediate read of the same address, WS=2
    sel = 1'b1;
    repeat (2) @(negedge clk);
    av_req(1'b1, 32'h5, 16'h1234, 2'b00, st, ac);
    chk("wt_wr_stall", st, 0);
    av_req(1'b0, 32'h5, 16'h0, 2'b00, st, ac2);
    chk("wt_rd_stall", st, 0);
    av_idle();
    base = rsp_data.size();
    we_low = 0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      if (!we_m) we_low++;
      if (k == 5) begin
        chk("wt_hold_we", we_m, 1'b1);
        chk("wt_hold_dq", dq_m, 16'h1234);
      end
      if (k == 6) begin
        chk("wt_turn_ce", ce_m, 1'b1);
        chk("wt_turn_oe", oe_m, 1'b1);
      end
      if (k == 7) chk("wt_read_oe", oe_m, 1'b0);
    end
    @(negedge clk);
    chk("wt_we_cycles", we_low, 3);
    chk("wt_rsp_count", rsp_data.size() - base, 1);
    if (rsp_data.size() > base) begin
      chk("wt_data", rsp_data[base], 16'h1234);
      chk("wt_latency", rsp_cyc[base] - ac, 10);
    end

    // Six back-to-back reads against the credit limit, WS=2
    for (int i = 0; i < 6; i++) av_req(1'b1, 32'h40 + i, 16'h1000 + 16'(i) * 16'h0111, 2'b00, st, ac);
    av_idle();
    repeat (30) @(negedge clk);
    base = rsp_data.size();
    for (int i = 0; i < 6; i++) av_req(1'b0, 32'h40 + i, 16'h0, 2'b00, rst_st[i], rst_ac[i]);
    av_idle();
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_stall%0d", i), rst_st[i], 0);
    chk("b2b_stall4", rst_st[4], 2);
    chk("b2b_stall5", rst_st[5], 2);
    chk("b2b_count", rsp_data.size() - base, 6);
    if (rsp_data.size() >= base + 6) begin
      chk("b2b_first_lat", rsp_cyc[base] - rst_ac[0], 5);
      for (int i = 0; i < 6; i++)
        chk($sformatf("b2b_data%0d", i), rsp_data[base+i], 16'h1000 + 16'(i) * 16'h0111);
      for (int i = 0; i < 5; i++)
        chk($sformatf("b2b_gap%0d", i), rsp_cyc[base+i+1] - rsp_cyc[base+i], 3);
    end

    // Reset in the middle of a read with two commands queued
    av_req(1'b0, 32'h40, 16'h0, 2'b00, st, ac);
    av_req(1'b0, 32'h41, 16'h0, 2'b00, st, ac);
    av_req(1'b0, 32'h42, 16'h0, 2'b00, st, ac);
    @(posedge clk); #3;
    rd_n = 1'b1; wr_n = 1'b1;
    chk("mid_in_read", oe_m, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_ce", ce_m, 1'b1);
    chk("mid_oe", oe_m, 1'b1);
    chk("mid_addr", asr_m, 18'h0);
    chk("mid_out", out_m, 3'd0);
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdv_m) n++;
    end
    chk("post_rst_rdv", n, 0);
    chk("post_rst_out", out_m, 3'd0);
    chk("post_rst_wait", wait_m, 1'b0);
    base = rsp_data.size();
    av_req(1'b0, 32'h41, 16'h0, 2'b00, st, ac);
    av_idle();
    repeat (8) @(negedge clk);
    chk("post_rst_count", rsp_data.size() - base, 1);
    if (rsp_data.size() > base) chk("post_rst_data", rsp_data[base], 16'h1111);

    chk("contention0", cont0, 0);
    chk("contention2", cont2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/avalon_sram_bridge.md
Name: avalon_sram_bridge

Overview:
Parametrised Avalon-MM slave to asynchronous-SRAM bridge. It generalises the fixed 16-bit, 18-bit-address SRAM port with configurable data/address width, command and response buffer depths, and programmable SRAM wait states. It adds credit-based read flow control, so readdatavalid can never overflow, and write-to-read bus turnaround. It sits between the system interconnect and the off-chip SRAM pins.

Parameters:
DATA_W, 16, data width in bits; multiple of 8; NB = DATA_W/8 byte lanes
ADDR_W, 18, SRAM word-address width
AV_ADDR_W, 32, Avalon address width; word address, low ADDR_W bits used
CMD_DEPTH, 4, command FIFO entries (>=2)
RSP_DEPTH, 4, response FIFO entries and maximum outstanding reads (>=2)
WAIT_STATES, 0, extra SRAM cycles per access (0..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
read_n  in  1  Avalon read request, active low
write_n  in  1  Avalon write request, active low
address  in  AV_ADDR_W  word address
writeData  in  DATA_W  write data
byteEnable_n  in  NB  byte enables, active low
readData  out  DATA_W  read data, valid with readdatavalid
waitrequest  out  1  request stalled this cycle
readdatavalid  out  1  one read response per asserted cycle
rd_outstanding  out  $clog2(RSP_DEPTH+1)  reads accepted but not yet returned
dq_sram  inout  DATA_W  SRAM data bus
address_sram  out  ADDR_W  SRAM address
ce_n_sram, oe_n_sram, we_n_sram  out  1 each  SRAM strobes, active low
be_n_sram  out  NB  SRAM byte strobes, active low

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty, FSM=IDLE, rd_outstanding=0, readdatavalid=0, readData=0, waitrequest=0, ce_n/oe_n/we_n=1, be_n all 1, address_sram=0, dq_sram hi-Z. Reset mid-access aborts the access immediately and drops all pending reads.
- Request: write wins if read_n and write_n are both low; that read is ignored and not counted.
- waitrequest (combinational) = cmd_full OR (read requested AND rd_outstanding == RSP_DEPTH).
- A request is accepted in a cycle where it is asserted and waitrequest=0. An accepted request pushes {op, address[ADDR_W-1:0], byteEnable_n, writeData} into the command FIFO.
- rd_outstanding: +1 on an accepted read, -1 on a readdatavalid cycle, net 0 when both happen in the same cycle.
- FSM states: IDLE, READ, WRITE, HOLD, TURN. All SRAM pin outputs are registered.
  - IDLE: if the command FIFO is non-empty, pop it and go to READ or WRITE.
  - READ lasts WAIT_STATES+1 cycles with ce_n=0, oe_n=0, we_n=1, be_n=entry, dq hi-Z. dq is sampled at the end of the last cycle and pushed to the response FIFO. The response FIFO cannot be full here because of the credit limit.
  - WRITE lasts WAIT_STATES+1 cycles with ce_n=0, we_n=0, oe_n=1, dq driven with the entry data, be_n=entry. It is followed by HOLD (1 cycle): we_n=1, address and data still driven.
  - Next-state rules: after READ, the next command is popped in the final cycle, so back-to-back reads have no gap. After HOLD, a next read goes through TURN (1 cycle, dq hi-Z, strobes high); a next write goes straight to WRITE; an empty FIFO goes to IDLE.
- Response: readdatavalid = response FIFO not empty; readData = head entry, popped in the same cycle. There is no backpressure. readData=0 when invalid.
- Read latency with an empty pipe, request accepted in cycle T: readdatavalid in cycle T+3+WAIT_STATES.
- Throughput: reads 1 per (WAIT_STATES+1) cycles; writes 1 per (WAIT_STATES+2) cycles.
- FIFO pointers wrap modulo depth. Full and empty use an extra pointer bit or a counter. Pushes and pops in the same cycle are legal at every fill level.
- Ordering: commands execute strictly in acceptance order. A read after a write to the same address returns the new data.

Test Plan:
- Reset then single write: addr 0x00010, data 0xBEEF, be_n=00, WS=0 -> we_n low 1 cycle, address_sram=0x00010, dq=0xBEEF, then HOLD, then IDLE. waitrequest stays 0.
- Read back 0x00010 (SRAM model returns 0xBEEF) -> readdatavalid exactly 3 cycles after acceptance, readData=0xBEEF, rd_outstanding goes 1 then 0.
- 6 back-to-back reads, RSP_DEPTH=4, SRAM response delayed -> waitrequest asserted on the 5th read until the first readdatavalid; all 6 data returned in order with no gaps between READ accesses.
- Write 0x1234 to addr 5, then immediately read addr 5, WS=2 -> write held 3+1 cycles, TURN cycle with dq hi-Z, readData=0x1234. No cycle where the bridge and the SRAM model both drive dq.
- byteEnable_n=10 write of 0xAA55 over 0xFFFF -> be_n_sram=10; subsequent read returns 0xFF55.
- Assert rst low mid-READ with 2 commands queued -> pins idle in the same cycle; after release, no readdatavalid, rd_outstanding=0, waitrequest=0.
